// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM write/read arbiter.
package sdram_arb_pkg;

    localparam int DEF_ADDR_W         = 22;
    localparam int DEF_DATA_W         = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

endpackage

// File: rtl/sdram_arb_rr_module.sv
// Two-way round-robin decision between the write and read requesters.
module sdram_arb_rr_module
    import sdram_arb_pkg::*;
(
    input  logic   wrReq_i,
    input  logic   rdReq_i,
    input  grant_e lastGrant_i,
    output logic   grantValid_o,
    output grant_e grant_o
);

    // A lone request wins outright; on a tie the side not served last wins.
    always_comb begin
        grantValid_o = wrReq_i | rdReq_i;
        grant_o      = GRANT_WR;
        if (wrReq_i && rdReq_i) begin
            grant_o = (lastGrant_i == GRANT_RD) ? GRANT_WR : GRANT_RD;
        end else if (rdReq_i) begin
            grant_o = GRANT_RD;
        end
    end

endmodule

// File: rtl/sdram_arbiter_module.sv
// Arbiter sharing one SDRAM controller between a write and a read requester.
// Optional watchdog on the transfer phase: define SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter_module
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Wr_Req_Sig,
    input  logic [ADDR_W-1:0] Wr_Addr,
    input  logic [DATA_W-1:0] Wr_Data,
    output logic              Wr_Done_Sig,
    input  logic              Rd_Req_Sig,
    input  logic [ADDR_W-1:0] Rd_Addr,
    output logic [DATA_W-1:0] Rd_Data,
    output logic              Rd_Done_Sig,
    output logic              WrEN_Sig,
    output logic              RdEN_Sig,
    input  logic              Done_Sig,
    input  logic              Busy_Sig,
    output logic [ADDR_W-1:0] BRC_Addr,
    output logic [DATA_W-1:0] WrData,
    input  logic [DATA_W-1:0] RdData,
    output logic              Timeout_Err_Sig
);

    state_e            state_q;
    grant_e            lastGrant_q;
    logic              wrEn_q;
    logic              rdEn_q;
    logic              wrDone_q;
    logic              rdDone_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wrData_q;
    logic [DATA_W-1:0] rdData_q;

    logic              grantValid;
    grant_e            grant;
    logic              timeoutHit;
    logic              xferEnd;

    sdram_arb_rr_module uRr (
        .wrReq_i      (Wr_Req_Sig),
        .rdReq_i      (Rd_Req_Sig),
        .lastGrant_i  (lastGrant_q),
        .grantValid_o (grantValid),
        .grant_o      (grant)
    );

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeoutErr_q;
    logic             active;

    assign active     = (state_q == WRITE) || (state_q == READ);
    assign timeoutHit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count cycles spent waiting on the controller; restart on every new transfer.
    always_comb begin
        cnt_d = '0;
        if (active && !xferEnd) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Watchdog counter and its one-cycle error pulse (only when Done_Sig never came).
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cnt_q        <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            timeoutErr_q <= active && timeoutHit && !Done_Sig;
        end
    end

    assign Timeout_Err_Sig = timeoutErr_q;
`else
    // No watchdog: transfers wait on Done_Sig forever and the error never fires.
    assign timeoutHit      = 1'b0;
    assign Timeout_Err_Sig = (TIMEOUT_CYCLES < 0);
`endif

    assign xferEnd = Done_Sig | timeoutHit;

    // Main arbitration FSM with registered enables, done pulses and data paths.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            lastGrant_q <= GRANT_RD;
            wrEn_q      <= 1'b0;
            rdEn_q      <= 1'b0;
            wrDone_q    <= 1'b0;
            rdDone_q    <= 1'b0;
            addr_q      <= '0;
            wrData_q    <= '0;
            rdData_q    <= '0;
        end else begin
            wrDone_q <= 1'b0;
            rdDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!Busy_Sig && grantValid) begin
                        if (grant == GRANT_WR) begin
                            addr_q   <= Wr_Addr;
                            wrData_q <= Wr_Data;
                            wrEn_q   <= 1'b1;
                            state_q  <= WRITE;
                        end else begin
                            addr_q  <= Rd_Addr;
                            rdEn_q  <= 1'b1;
                            state_q <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (xferEnd) begin
                        wrEn_q      <= 1'b0;
                        wrDone_q    <= 1'b1;
                        lastGrant_q <= GRANT_WR;
                        state_q     <= RELEASE;
                    end
                end
                READ: begin
                    if (xferEnd) begin
                        if (Done_Sig) begin
                            rdData_q <= RdData;
                        end
                        rdEn_q      <= 1'b0;
                        rdDone_q    <= 1'b1;
                        lastGrant_q <= GRANT_RD;
                        state_q     <= RELEASE;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign WrEN_Sig    = wrEn_q;
    assign RdEN_Sig    = rdEn_q;
    assign Wr_Done_Sig = wrDone_q;
    assign Rd_Done_Sig = rdDone_q;
    assign BRC_Addr    = addr_q;
    assign WrData      = wrData_q;
    assign Rd_Data     = rdData_q;

endmodule

// File: tb/tb_sdram_arbiter_module.sv
// Directed self-checking bench for sdram_arbiter_module.
// Covers the SDRAM_ARB_TIMEOUT_EN build as well when that macro is defined.
module tb_sdram_arbiter_module;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    logic              CLK;
    logic              RSTn;
    logic              Wr_Req_Sig;
    logic [ADDR_W-1:0] Wr_Addr;
    logic [DATA_W-1:0] Wr_Data;
    logic              Wr_Done_Sig;
    logic              Rd_Req_Sig;
    logic [ADDR_W-1:0] Rd_Addr;
    logic [DATA_W-1:0] Rd_Data;
    logic              Rd_Done_Sig;
    logic              WrEN_Sig;
    logic              RdEN_Sig;
    logic              Done_Sig;
    logic              Busy_Sig;
    logic [ADDR_W-1:0] BRC_Addr;
    logic [DATA_W-1:0] WrData;
    logic [DATA_W-1:0] RdData;
    logic              Timeout_Err_Sig;

    int checkCount = 0;
    int passCount  = 0;

    sdram_arbiter_module #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .Wr_Req_Sig      (Wr_Req_Sig),
        .Wr_Addr         (Wr_Addr),
        .Wr_Data         (Wr_Data),
        .Wr_Done_Sig     (Wr_Done_Sig),
        .Rd_Req_Sig      (Rd_Req_Sig),
        .Rd_Addr         (Rd_Addr),
        .Rd_Data         (Rd_Data),
        .Rd_Done_Sig     (Rd_Done_Sig),
        .WrEN_Sig        (WrEN_Sig),
        .RdEN_Sig        (RdEN_Sig),
        .Done_Sig        (Done_Sig),
        .Busy_Sig        (Busy_Sig),
        .BRC_Addr        (BRC_Addr),
        .WrData          (WrData),
        .RdData          (RdData),
        .Timeout_Err_Sig (Timeout_Err_Sig)
    );

    // Free-running 100 MHz clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed hang, required completion");
        $fatal(1, "[TB] simulation hang");
    end

    // Drive one set of input levels, then step to 1 ns past the next rising edge.
    task automatic applyStimulus(input logic wr, input logic rd, input logic busy, input logic done);
        Wr_Req_Sig = wr;
        Rd_Req_Sig = rd;
        Busy_Sig   = busy;
        Done_Sig   = done;
        @(posedge CLK);
        #1;
    endtask

    // Compare one observed value against its hand-derived expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Directed test sequence.
    initial begin
        int  hi;
        bit  seen;
        bit  expWr;

        RSTn       = 1'b0;
        Wr_Req_Sig = 1'b0;
        Rd_Req_Sig = 1'b0;
        Busy_Sig   = 1'b0;
        Done_Sig   = 1'b0;
        Wr_Addr    = 22'h01234;
        Wr_Data    = 16'hA5A5;
        Rd_Addr    = 22'h2A5F3;
        RdData     = 16'h0000;

        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rstWrEN", WrEN_Sig, 0);
        checkOutput("rstRdEN", RdEN_Sig, 0);
        checkOutput("rstDone", {Wr_Done_Sig, Rd_Done_Sig}, 0);
        checkOutput("rstAddr", BRC_Addr, 0);
        checkOutput("rstWrData", WrData, 0);
        checkOutput("rstRdData", Rd_Data, 0);
        checkOutput("rstTimeout", Timeout_Err_Sig, 0);
        RSTn = 1'b1;

        // Controller busy: write request must wait.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 1, 0);
            checkOutput("busyNoEn", {WrEN_Sig, RdEN_Sig}, 0);
        end
        applyStimulus(1, 0, 0, 0);
        checkOutput("busyFallWrEN", WrEN_Sig, 1);
        checkOutput("busyFallRdEN", RdEN_Sig, 0);
        checkOutput("wrAddr", BRC_Addr, 22'h01234);
        checkOutput("wrData", WrData, 16'hA5A5);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("wrEnHeld", WrEN_Sig, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("wrEnDrop", WrEN_Sig, 0);
        checkOutput("wrDonePulse", Wr_Done_Sig, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrDoneOneCycle", Wr_Done_Sig, 0);

        // Stray Done_Sig while idle is ignored.
        applyStimulus(0, 0, 0, 1);
        checkOutput("idleDoneIgnored", {Wr_Done_Sig, Rd_Done_Sig, WrEN_Sig, RdEN_Sig}, 0);

        // Re-reset, then both requesters held high: W,R,W,R.
        RSTn = 1'b0;
        applyStimulus(0, 0, 0, 0);
        RSTn    = 1'b1;
        Wr_Addr = 22'h00111;
        for (int k = 0; k < 4; k++) begin
            expWr  = (k % 2 == 0);
            RdData = (k == 1) ? 16'h1234 : 16'hBEEF;
            applyStimulus(1, 1, 0, 0);
            checkOutput("rrWrEN", WrEN_Sig, expWr);
            checkOutput("rrRdEN", RdEN_Sig, !expWr);
            checkOutput("rrAddr", BRC_Addr, expWr ? 22'h00111 : 22'h2A5F3);
            applyStimulus(1, 1, 0, 1);
            checkOutput("rrEnOff", {WrEN_Sig, RdEN_Sig}, 0);
            checkOutput("rrDone", {Wr_Done_Sig, Rd_Done_Sig}, expWr ? 2'b10 : 2'b01);
            checkOutput("rrRdData", Rd_Data, (k == 0) ? 16'h0000 : (k == 3) ? 16'hBEEF : 16'h1234);
            applyStimulus(1, 1, 0, 0);
            checkOutput("rrDoneOneCycle", {Wr_Done_Sig, Rd_Done_Sig}, 0);
        end
        RdData = 16'h0000;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rdDataHold", Rd_Data, 16'hBEEF);

        // Reset in the middle of a write.
        applyStimulus(1, 0, 0, 0);
        checkOutput("midWrEN", WrEN_Sig, 1);
        RSTn = 1'b0;
        applyStimulus(1, 0, 0, 0);
        checkOutput("midRstWrEN", WrEN_Sig, 0);
        checkOutput("midRstNoDone", Wr_Done_Sig, 0);
        RSTn = 1'b1;
        applyStimulus(1, 0, 0, 0);
        checkOutput("postRstWrEN", WrEN_Sig, 1);
        checkOutput("postRstNoDone", Wr_Done_Sig, 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("postRstWrDone", Wr_Done_Sig, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        // Write that never receives Done_Sig.
        applyStimulus(1, 0, 0, 0);
        checkOutput("toGrant", WrEN_Sig, 1);
`ifdef SDRAM_ARB_TIMEOUT_EN
        hi   = 1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            applyStimulus(1, 0, 0, 0);
            if (WrEN_Sig) hi++;
            else seen = 1'b1;
        end
        checkOutput("toEnCycles", hi, 16);
        checkOutput("toErrPulse", Timeout_Err_Sig, 1);
        checkOutput("toWrDone", Wr_Done_Sig, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("toErrOneCycle", Timeout_Err_Sig, 0);
`else
        hi   = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1, 0, 0, 0);
            if (WrEN_Sig) hi++;
            if (Timeout_Err_Sig || Wr_Done_Sig) seen = 1'b1;
        end
        checkOutput("noToEnHigh", hi, 100);
        checkOutput("noToPulse", seen, 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("noToFinalDone", Wr_Done_Sig, 1);
        applyStimulus(0, 0, 0, 0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
